// File: rtl/instr_mem_loader.sv
// Byte-serial loader: assembles little-endian 32-bit words into instruction memory and
// holds the CPU in reset until the image is written. Optional checksum: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned DEPTH_WORDS = 16,
    parameter logic [63:0] BASE_ADDR   = 64'd0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [7:0]                     in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic                           mem_we,
    output logic [63:0]                    mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           cpu_reset,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(DEPTH_WORDS):0]   word_count
);

    localparam int CW = $clog2(DEPTH_WORDS) + 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, CSUM} state_t;
    localparam state_t AFTER_LAST = CSUM;
    logic [7:0] csum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t     state, state_nxt;
    logic [1:0] byte_idx;
    logic       last_seen;
    logic       overflow;

    assign overflow = (word_count == CW'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cpu_reset = 1'b1;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    // Overflow bytes are swallowed; only in_last can still end the load.
                    if (overflow) begin
                        if (in_last) state_nxt = AFTER_LAST;
                    end else if (byte_idx == 2'd3 || in_last) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                state_nxt = last_seen ? AFTER_LAST : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_nxt = LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            word_count <= '0;
            byte_idx   <= 2'd0;
            last_seen  <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else if ((state == IDLE || state == DONE) && start) begin
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            byte_idx   <= 2'd0;
            last_seen  <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            if (state == LOAD && in_valid) begin
                last_seen <= in_last;
`ifdef LOADER_CHECKSUM_EN
                csum      <= csum + in_data;
`endif
                if (overflow) begin
                    error <= 1'b1;
                end else begin
                    // Byte 0 rewrites the whole word so a short final word is zero-padded.
                    if (byte_idx == 2'd0) mem_wdata <= {24'd0, in_data};
                    else                  mem_wdata[8*byte_idx +: 8] <= in_data;
                    byte_idx <= byte_idx + 2'd1;
                end
            end
            if (state == WRITE) begin
                word_count <= word_count + CW'(1);
                mem_addr   <= mem_addr + 64'd4;
                byte_idx   <= 2'd0;
            end
`ifdef LOADER_CHECKSUM_EN
            if (state == CSUM && in_valid && 8'(csum + in_data) != 8'd0) error <= 1'b1;
`endif
        end
    end

endmodule
